// File: rtl/axi4_arbiter2_if.sv
// Full AXI4 bundle (AR, R, AW, W, B) shared by the arbiter's requester and downstream ports.
interface axi4_arbiter2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi4_arbiter2.sv
// Two-requester AXI4 arbiter keeping one transaction (read or write) outstanding downstream.
// Define AXI4_ARBITER2_RR_EN for round-robin on collisions; otherwise requester 1 wins.
module axi4_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic            clock,
  input  logic            reset,
  axi4_arbiter2_if.slave  in0,
  axi4_arbiter2_if.slave  in1,
  axi4_arbiter2_if.master out
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready;
  logic [ID_W-1:0]   s_arid, s_awid;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [7:0]        s_arlen, s_awlen;
  logic [2:0]        s_arsize, s_awsize;
  logic [1:0]        s_arburst, s_awburst;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;

  assign s_arvalid = grant_q ? in1.arvalid : in0.arvalid;
  assign s_arid    = grant_q ? in1.arid    : in0.arid;
  assign s_araddr  = grant_q ? in1.araddr  : in0.araddr;
  assign s_arlen   = grant_q ? in1.arlen   : in0.arlen;
  assign s_arsize  = grant_q ? in1.arsize  : in0.arsize;
  assign s_arburst = grant_q ? in1.arburst : in0.arburst;
  assign s_rready  = grant_q ? in1.rready  : in0.rready;
  assign s_awvalid = grant_q ? in1.awvalid : in0.awvalid;
  assign s_awid    = grant_q ? in1.awid    : in0.awid;
  assign s_awaddr  = grant_q ? in1.awaddr  : in0.awaddr;
  assign s_awlen   = grant_q ? in1.awlen   : in0.awlen;
  assign s_awsize  = grant_q ? in1.awsize  : in0.awsize;
  assign s_awburst = grant_q ? in1.awburst : in0.awburst;
  assign s_wvalid  = grant_q ? in1.wvalid  : in0.wvalid;
  assign s_wdata   = grant_q ? in1.wdata   : in0.wdata;
  assign s_wstrb   = grant_q ? in1.wstrb   : in0.wstrb;
  assign s_wlast   = grant_q ? in1.wlast   : in0.wlast;
  assign s_bready  = grant_q ? in1.bready  : in0.bready;

  logic ar_en, r_en, aw_en, w_en, b_en;
  // NOTE: reset gates the channel enables directly, because the synchronous reset only
  // moves the FSM at the next edge and the bus must already be quiet during reset.
  assign ar_en = !reset && (state_q == RADDR);
  assign r_en  = !reset && (state_q == RDATA);
  assign aw_en = !reset && (state_q == WADDR) && !aw_done_q;
  assign w_en  = !reset && (state_q == WADDR) && !w_done_q;
  assign b_en  = !reset && (state_q == WRESP);

  assign out.arvalid = ar_en & s_arvalid;
  assign out.arid    = ar_en ? s_arid    : '0;
  assign out.araddr  = ar_en ? s_araddr  : '0;
  assign out.arlen   = ar_en ? s_arlen   : '0;
  assign out.arsize  = ar_en ? s_arsize  : '0;
  assign out.arburst = ar_en ? s_arburst : '0;
  assign out.rready  = r_en & s_rready;
  assign out.awvalid = aw_en & s_awvalid;
  assign out.awid    = aw_en ? s_awid    : '0;
  assign out.awaddr  = aw_en ? s_awaddr  : '0;
  assign out.awlen   = aw_en ? s_awlen   : '0;
  assign out.awsize  = aw_en ? s_awsize  : '0;
  assign out.awburst = aw_en ? s_awburst : '0;
  assign out.wvalid  = w_en & s_wvalid;
  assign out.wdata   = w_en ? s_wdata : '0;
  assign out.wstrb   = w_en ? s_wstrb : '0;
  assign out.wlast   = w_en & s_wlast;
  assign out.bready  = b_en & s_bready;

  logic              g_arready, g_rvalid, g_rlast, g_awready, g_wready, g_bvalid;
  logic [ID_W-1:0]   g_rid, g_bid;
  logic [DATA_W-1:0] g_rdata;
  logic [1:0]        g_rresp, g_bresp;

  assign g_arready = ar_en & out.arready;
  assign g_rvalid  = r_en & out.rvalid;
  assign g_rid     = r_en ? out.rid   : '0;
  assign g_rdata   = r_en ? out.rdata : '0;
  assign g_rresp   = r_en ? out.rresp : '0;
  assign g_rlast   = r_en & out.rlast;
  assign g_awready = aw_en & out.awready;
  assign g_wready  = w_en & out.wready;
  assign g_bvalid  = b_en & out.bvalid;
  assign g_bid     = b_en ? out.bid   : '0;
  assign g_bresp   = b_en ? out.bresp : '0;

  // The requester that does not hold the grant sees every response signal at zero.
  assign in0.arready = !grant_q & g_arready;
  assign in0.rvalid  = !grant_q & g_rvalid;
  assign in0.rid     = grant_q ? '0 : g_rid;
  assign in0.rdata   = grant_q ? '0 : g_rdata;
  assign in0.rresp   = grant_q ? '0 : g_rresp;
  assign in0.rlast   = !grant_q & g_rlast;
  assign in0.awready = !grant_q & g_awready;
  assign in0.wready  = !grant_q & g_wready;
  assign in0.bvalid  = !grant_q & g_bvalid;
  assign in0.bid     = grant_q ? '0 : g_bid;
  assign in0.bresp   = grant_q ? '0 : g_bresp;
  assign in1.arready = grant_q & g_arready;
  assign in1.rvalid  = grant_q & g_rvalid;
  assign in1.rid     = grant_q ? g_rid   : '0;
  assign in1.rdata   = grant_q ? g_rdata : '0;
  assign in1.rresp   = grant_q ? g_rresp : '0;
  assign in1.rlast   = grant_q & g_rlast;
  assign in1.awready = grant_q & g_awready;
  assign in1.wready  = grant_q & g_wready;
  assign in1.bvalid  = grant_q & g_bvalid;
  assign in1.bid     = grant_q ? g_bid   : '0;
  assign in1.bresp   = grant_q ? g_bresp : '0;

  logic ar_hs, r_last_hs, aw_hs, w_last_hs, b_hs;
  assign ar_hs     = out.arvalid & out.arready;
  assign r_last_hs = out.rvalid & out.rready & out.rlast;
  assign aw_hs     = out.awvalid & out.awready;
  assign w_last_hs = out.wvalid & out.wready & out.wlast;
  assign b_hs      = out.bvalid & out.bready;

  logic req0, req1, pick, pick_ar;
  assign req0 = in0.arvalid | in0.awvalid;
  assign req1 = in1.arvalid | in1.awvalid;
`ifdef AXI4_ARBITER2_RR_EN
  logic last_grant_q, last_grant_d;
  assign pick         = (req0 & req1) ? ~last_grant_q : req1;
  assign last_grant_d = (state_q != IDLE && state_d == IDLE) ? grant_q : last_grant_q;
`else
  assign pick = req1;
`endif
  assign pick_ar = pick ? in1.arvalid : in0.arvalid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: if (req0 | req1) begin
        grant_d = pick;
        state_d = pick_ar ? RADDR : WADDR;
      end
      RADDR: if (ar_hs) state_d = RDATA;
      RDATA: if (r_last_hs) state_d = IDLE;
      WADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
`ifdef AXI4_ARBITER2_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
`ifdef AXI4_ARBITER2_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end
endmodule
